// File: rtl/selftest_pkg.sv
// selftest_pkg: shared types and defaults for the unit self-test sequencer.
// IDX_W helper sizes the stage index for any stage count.
package selftest_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP,
    DONE
  } st_t;

  localparam int N_STAGES_DEF = 6;
  localparam int TIMEOUT_DEF  = 1000;
  localparam int CNT_W_DEF    = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/selftest_watchdog.sv
// selftest_watchdog: per-stage wait counter, saturating at TIMEOUT.
// Only built when SELFTEST_TIMEOUT_EN is defined.
`ifdef SELFTEST_TIMEOUT_EN
module selftest_watchdog
  import selftest_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIM  = W'(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  // count RUN cycles since the last clear, holding at the limit
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && cnt != LIM) begin
      cnt <= cnt + W'(1);
    end
  end

  // the cycle carrying count TIMEOUT-1 is the last one allowed
  assign expired = enable && (cnt >= LAST);

endmodule
`endif

// File: rtl/selftest_sequencer.sv
// selftest_sequencer: runs each self-test stage in turn, records timeouts.
// SELFTEST_TIMEOUT_EN adds the per-stage watchdog; without it RUN never times out.
module selftest_sequencer
  import selftest_pkg::*;
#(
  parameter int N_STAGES = N_STAGES_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  localparam int IDX_W   = idx_w(N_STAGES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic [N_STAGES-1:0] stage_finish,
  output logic [N_STAGES-1:0] stage_start,
  output logic [IDX_W-1:0]    cur_stage,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_STAGES-1:0] fail_mask,
  output logic [CNT_W-1:0]    run_cycles
);

  localparam logic [IDX_W-1:0]    LAST = IDX_W'(N_STAGES - 1);
  localparam logic [N_STAGES-1:0] ONE  = N_STAGES'(1);

  st_t                st, st_nx;
  logic [IDX_W-1:0]   cur, cur_nx;
  logic [N_STAGES-1:0] fmask, fmask_nx;
  logic [CNT_W-1:0]   cyc;
  logic               fin;
  logic               expired;
  logic               active;

  assign fin    = stage_finish[cur];
  assign active = (st == RUN) || (st == GAP);

`ifdef SELFTEST_TIMEOUT_EN
  logic wd_clear;
  logic wd_en;

  assign wd_clear = (st_nx == RUN) && (st != RUN);
  assign wd_en    = (st == RUN);

  selftest_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_en),
    .expired(expired)
  );
`else
  assign expired = (TIMEOUT < 0);
`endif

  // next state, stage index and timeout record
  always_comb begin
    st_nx    = st;
    cur_nx   = cur;
    fmask_nx = fmask;
    unique case (st)
      IDLE, DONE: begin
        if (go) begin
          st_nx    = RUN;
          cur_nx   = '0;
          fmask_nx = '0;
        end
      end
      RUN: begin
        if (fin) begin
          st_nx = GAP;
        end else if (expired) begin
          st_nx       = GAP;
          fmask_nx[cur] = 1'b1;
        end
      end
      GAP: begin
        if (cur == LAST) begin
          st_nx = DONE;
        end else begin
          st_nx  = RUN;
          cur_nx = cur + IDX_W'(1);
        end
      end
      default: st_nx = IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      cur         <= '0;
      fmask       <= '0;
      stage_start <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      st          <= st_nx;
      cur         <= cur_nx;
      fmask       <= fmask_nx;
      stage_start <= (st_nx == RUN) ? (ONE << cur_nx) : '0;
      busy        <= (st_nx == RUN) || (st_nx == GAP);
      done        <= (st_nx == DONE);
      pass        <= (st_nx == DONE) && ~|fmask_nx;
    end
  end

  // busy-cycle counter, cleared on a new run, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc <= '0;
    end else if ((st == IDLE || st == DONE) && go) begin
      cyc <= '0;
    end else if (active && ~&cyc) begin
      cyc <= cyc + CNT_W'(1);
    end
  end

  assign cur_stage  = cur;
  assign fail_mask  = fmask;
  assign run_cycles = cyc;

endmodule

// File: tb/tb_selftest_sequencer.sv
// tb_selftest_sequencer: randomized stage delays checked against a
// per-stage length model of the sequencer.
module tb_selftest_sequencer;
  import selftest_pkg::*;

  localparam int N     = 6;
  localparam int TO    = 8;
  localparam int CW    = 13;
  localparam int IW    = idx_w(N);
  localparam int NEVER = 1 << 30;
  localparam int BOUND = 20000;
  localparam longint CMAX = (longint'(1) << CW) - 1;
`ifdef SELFTEST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [N-1:0]  stage_finish;
  logic [N-1:0]  stage_start;
  logic [IW-1:0] cur_stage;
  logic          busy;
  logic          done;
  logic          pass;
  logic [N-1:0]  fail_mask;
  logic [CW-1:0] run_cycles;

  int total = 0;
  int bad   = 0;
  int dly[N];
  int age[N];

  int            exp_len[N];
  logic [N-1:0]  exp_mask;
  longint        exp_busy;
  longint        exp_cyc;

  selftest_sequencer #(
    .N_STAGES(N),
    .TIMEOUT (TO),
    .CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .stage_finish(stage_finish),
    .stage_start (stage_start),
    .cur_stage   (cur_stage),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_mask   (fail_mask),
    .run_cycles  (run_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // stage models: raise finish dly cycles after start, noise otherwise
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (stage_start[i]) begin
        stage_finish[i] = (age[i] >= dly[i]);
        age[i]++;
      end else begin
        age[i] = 0;
        stage_finish[i] = 1'($urandom_range(0, 1));
      end
    end
  end

  function automatic void model();
    longint sum = 0;
    exp_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (TO_EN && (longint'(dly[i]) + 1 > TO)) begin
        exp_len[i]  = TO;
        exp_mask[i] = 1'b1;
      end else begin
        exp_len[i] = dly[i] + 1;
      end
      sum += exp_len[i] + 1;
    end
    exp_busy = sum;
    exp_cyc  = (sum > CMAX) ? CMAX : sum;
  endfunction

  task automatic run_seq(input string tag, input bit hold_go);
    int len[N];
    int nxt = 0;
    int gaps = 0;
    int busy_n = 0;
    bit prev_on = 1'b0;
    bit fin = 1'b0;
    logic [N-1:0] one = 1;
    for (int i = 0; i < N; i++) len[i] = 0;
    model();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    if (!hold_go) go = 1'b0;
    chk({tag, "_clr_done"}, done, 0);
    chk({tag, "_clr_cyc"}, run_cycles, 0);
    chk({tag, "_clr_mask"}, fail_mask, 0);
    chk({tag, "_first"}, cur_stage, 0);
    for (int c = 0; c < BOUND; c++) begin
      if (done) begin
        fin = 1'b1;
        break;
      end
      if (busy) busy_n++;
      if (stage_start != '0) begin
        chk({tag, "_onehot"}, stage_start, one << cur_stage);
        if (!prev_on) begin
          chk({tag, "_order"}, cur_stage, nxt);
          nxt++;
        end
        if (int'(cur_stage) < N) len[cur_stage]++;
        prev_on = 1'b1;
      end else begin
        if (busy) gaps++;
        prev_on = 1'b0;
      end
      @(negedge clk);
    end
    go = 1'b0;
    chk({tag, "_reached_done"}, fin, 1);
    chk({tag, "_nstarts"}, nxt, N);
    chk({tag, "_gaps"}, gaps, N);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_len%0d", tag, i), len[i], exp_len[i]);
    end
    chk({tag, "_busy_n"}, busy_n, exp_busy);
    chk({tag, "_cyc"}, run_cycles, exp_cyc);
    chk({tag, "_mask"}, fail_mask, exp_mask);
    chk({tag, "_pass"}, pass, ~|exp_mask);
    chk({tag, "_last"}, cur_stage, N - 1);
    chk({tag, "_start0"}, stage_start, 0);
  endtask

  task automatic set_all(input int d);
    for (int i = 0; i < N; i++) dly[i] = d;
  endtask

  task automatic set_rand(input int hi);
    for (int i = 0; i < N; i++) dly[i] = $urandom_range(0, hi);
  endtask

  initial begin
    bit hit = 1'b0;
    rst = 1'b1;
    go = 1'b0;
    stage_finish = '0;
    set_all(0);
    repeat (3) @(negedge clk);
    chk("rst_start", stage_start, 0);
    chk("rst_cur", cur_stage, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_mask", fail_mask, 0);
    chk("rst_cyc", run_cycles, 0);
    rst = 1'b0;

    set_all(3);
    run_seq("fin3", 1'b0);
    chk("fin3_total", run_cycles, 30);

    set_all(0);
    run_seq("imm", 1'b0);
    chk("imm_total", run_cycles, 12);

`ifdef SELFTEST_TIMEOUT_EN
    set_all(0);
    dly[2] = NEVER;
    dly[1] = TO - 1;
    run_seq("tmo", 1'b0);
    chk("tmo_mask", fail_mask, 6'b000100);
`endif

    set_all(2);
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (cur_stage == 3 && stage_start != '0) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("mid_reach", hit, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_start", stage_start, 0);
    chk("mid_busy", busy, 0);
    chk("mid_cur", cur_stage, 0);
    chk("mid_cyc", run_cycles, 0);
    chk("mid_done", done, 0);
    rst = 1'b0;
    set_rand(5);
    run_seq("after_rst", 1'b0);

    set_rand(6);
    run_seq("hold", 1'b1);
    @(negedge clk);
    chk("hold_stay", done, 1);
    set_rand(6);
    run_seq("rerun", 1'b0);

    set_rand(3);
    dly[1] = 5000;
    run_seq("stall", 1'b0);

    set_rand(3);
    dly[0] = 8200;
    run_seq("sat", 1'b0);

    for (int r = 0; r < 4; r++) begin
      set_rand(12);
      run_seq($sformatf("rnd%0d", r), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
